// File: rtl/cpu_pkg.sv
// Shared decode constants for the single-cycle MIPS-subset core.
// Latency: n/a (constants and pure helper functions only).
// Backpressure: n/a.
package cpu_pkg;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  // ALU control codes; ALU_NONE makes the ALU output 0 for unsupported encodings
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_NONE = 4'b1111;

  // aluop encodings from the main decoder; 11 is used for "no ALU operation"
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_NONE  = 2'b11;

  // True for the R-type function codes the core implements
  function automatic logic funct_supported(input logic [5:0] funct);
    return (funct == FUNCT_ADD) || (funct == FUNCT_SUB) || (funct == FUNCT_AND) ||
           (funct == FUNCT_OR)  || (funct == FUNCT_SLT);
  endfunction

  // Sign-extend a 16-bit immediate to 32 bits
  function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// 32-bit ALU: add/sub/and/or/slt with zero flag; unknown control yields 0.
// Latency: purely combinational.
// Backpressure: none.
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  ctrl,
  output logic [31:0] result,
  output logic        zero
);

  // Select the operation; arithmetic wraps modulo 2^32
  always_comb begin
    result = 32'd0;
    case (ctrl)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: result = 32'd0;
    endcase
  end

  assign zero = (result == 32'd0);

endmodule

// File: rtl/cpu_regfile.sv
// 32x32 register file, two combinational read ports, one write port, $0 fixed at 0.
// Latency: reads combinational, write commits on the rising clk edge.
// Backpressure: none; reset clears every register asynchronously.
module cpu_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];

  // Next register state: one word replaced when enabled, never $0
  always_comb begin
    regs_d = regs_q;
    if (we && (wa != 5'd0)) begin
      regs_d[wa] = wd;
    end
  end

  // Register storage with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 32'd0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? 32'd0 : regs_q[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : regs_q[ra2];

endmodule

// File: rtl/cpu.sv
// Single-cycle MIPS-subset core: decode, regfile read, ALU, data memory, commit.
// Latency: addr->out combinational; reg/mem/PC updates commit on the rising clk edge.
// Backpressure: none; one instruction retires every cycle while rst is low.
module cpu
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  output logic [31:0] out
);

  // Instruction fields
  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm;
  logic [5:0]  funct;
  logic [31:0] simm;

  assign op    = addr[31:26];
  assign rs    = addr[25:21];
  assign rt    = addr[20:16];
  assign rd    = addr[15:11];
  assign imm   = addr[15:0];
  assign funct = addr[5:0];
  assign simm  = sign_ext16(imm);

  // Control signals
  logic       regdst;
  logic       jump;
  logic       branch;
  logic       memread;
  logic       memtoreg;
  logic [1:0] aluop;
  logic       memwrite;
  logic       alusrc;
  logic       regwrite;
  logic [3:0] alu_ctl;

  // Datapath
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] alu_b;
  logic [31:0] alu_res;
  logic        alu_zero;
  logic [31:0] wb_data;
  logic [4:0]  wb_reg;
  logic [5:0]  mem_idx;
  logic [31:0] mem_rdata;
  logic [31:0] mem_q [64];
  logic [31:0] mem_d [64];

  // Main decoder: anything not listed leaves every write disabled and the ALU idle
  always_comb begin
    regdst   = 1'b0;
    jump     = 1'b0;
    branch   = 1'b0;
    memread  = 1'b0;
    memtoreg = 1'b0;
    aluop    = ALUOP_NONE;
    memwrite = 1'b0;
    alusrc   = 1'b0;
    regwrite = 1'b0;
    case (op)
      OP_RTYPE: begin
        regdst   = 1'b1;
        aluop    = ALUOP_FUNCT;
        regwrite = funct_supported(funct);
      end
      OP_ADDI: begin
        alusrc   = 1'b1;
        aluop    = ALUOP_ADD;
        regwrite = 1'b1;
      end
      OP_LW: begin
        alusrc   = 1'b1;
        aluop    = ALUOP_ADD;
        memread  = 1'b1;
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      OP_SW: begin
        alusrc   = 1'b1;
        aluop    = ALUOP_ADD;
        memwrite = 1'b1;
      end
      OP_BEQ: begin
        branch = 1'b1;
        aluop  = ALUOP_SUB;
      end
      OP_J: begin
        jump = 1'b1;
      end
      default: begin
        aluop = ALUOP_NONE;
      end
    endcase
  end

  // ALU control: unsupported funct maps to ALU_NONE so the result is 0
  always_comb begin
    alu_ctl = ALU_NONE;
    case (aluop)
      ALUOP_ADD: alu_ctl = ALU_ADD;
      ALUOP_SUB: alu_ctl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: alu_ctl = ALU_ADD;
          FUNCT_SUB: alu_ctl = ALU_SUB;
          FUNCT_AND: alu_ctl = ALU_AND;
          FUNCT_OR:  alu_ctl = ALU_OR;
          FUNCT_SLT: alu_ctl = ALU_SLT;
          default:   alu_ctl = ALU_NONE;
        endcase
      end
      default: alu_ctl = ALU_NONE;
    endcase
  end

  assign wb_reg = regdst ? rd : rt;

  cpu_regfile u_rf (
    .clk (clk),
    .rst (rst),
    .we  (regwrite),
    .ra1 (rs),
    .ra2 (rt),
    .wa  (wb_reg),
    .wd  (wb_data),
    .rd1 (rs_val),
    .rd2 (rt_val)
  );

  assign alu_b = alusrc ? simm : rt_val;

  cpu_alu u_alu (
    .a      (rs_val),
    .b      (alu_b),
    .ctrl   (alu_ctl),
    .result (alu_res),
    .zero   (alu_zero)
  );

  assign out = alu_res;

  // Data memory is word-addressed by the byte address bits [7:2]
  assign mem_idx   = alu_res[7:2];
  assign mem_rdata = memread ? mem_q[mem_idx] : 32'd0;
  assign wb_data   = memtoreg ? mem_rdata : alu_res;

  // Next memory state: store replaces one word
  always_comb begin
    mem_d = mem_q;
    if (memwrite) begin
      mem_d[mem_idx] = rt_val;
    end
  end

  // Data memory storage with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) begin
        mem_q[i] <= 32'd0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Next PC: jump beats branch; branch taken when rs-rt is zero
  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    pc_d     = pc_plus4;
    if (jump) begin
      pc_d = {pc_plus4[31:28], addr[25:0], 2'b00};
    end else if (branch && alu_zero) begin
      pc_d = pc_plus4 + {simm[29:0], 2'b00};
    end
  end

  // Program counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= 32'd0;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: tb/tb_cpu.sv
// Bench for cpu: directed vector table, reset corners, then random programs vs a model.
// Latency: checks out mid-cycle, architectural state just after each rising edge.
// Backpressure: n/a.
module tb_cpu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] out;

  cpu dut (
    .clk  (clk),
    .rst  (rst),
    .addr (addr),
    .out  (out)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Architectural model state
  logic [31:0] m_regs [32];
  logic [31:0] m_mem  [64];
  logic [31:0] m_pc;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] exp_out;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    for (int i = 0; i < 64; i++) m_mem[i] = 32'd0;
    m_pc = 32'd0;
  endtask

  function automatic logic [31:0] sx(input logic [31:0] ins);
    return {{16{ins[15]}}, ins[15:0]};
  endfunction

  // Expected ALU result straight from the instruction semantics
  function automatic logic [31:0] m_result(input logic [31:0] ins);
    logic [31:0] a, b;
    a = m_regs[ins[25:21]];
    b = m_regs[ins[20:16]];
    case (ins[31:26])
      6'h00: case (ins[5:0])
        6'h20: return a + b;
        6'h22: return a - b;
        6'h24: return a & b;
        6'h25: return a | b;
        6'h2A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        default: return 32'd0;
      endcase
      6'h08, 6'h23, 6'h2B: return a + sx(ins);
      6'h04: return a - b;
      default: return 32'd0;
    endcase
  endfunction

  // Apply the architectural effect of one instruction to the model
  task automatic model_commit(input logic [31:0] ins);
    logic [31:0] a, b, ea, nxt;
    a   = m_regs[ins[25:21]];
    b   = m_regs[ins[20:16]];
    ea  = a + sx(ins);
    nxt = m_pc + 32'd4;
    case (ins[31:26])
      6'h00: begin
        if (ins[5:0] inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A} && ins[15:11] != 5'd0)
          m_regs[ins[15:11]] = m_result(ins);
      end
      6'h08: if (ins[20:16] != 5'd0) m_regs[ins[20:16]] = ea;
      6'h23: if (ins[20:16] != 5'd0) m_regs[ins[20:16]] = m_mem[ea[7:2]];
      6'h2B: m_mem[ea[7:2]] = b;
      6'h04: if (a == b) nxt = m_pc + 32'd4 + (sx(ins) << 2);
      6'h02: nxt = {nxt[31:28], ins[25:0], 2'b00};
      default: ;
    endcase
    m_pc = nxt;
  endtask

  // Run one instruction: check out against the model, then PC after the edge
  task automatic run_instr(input logic [31:0] ins, input string name, input bit chk_out);
    addr = ins;
    @(negedge clk);
    if (chk_out) check({name, " out"}, out, m_result(ins));
    model_commit(ins);
    @(posedge clk);
    #1;
    check({name, " pc"}, dut.pc_q, m_pc);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0]  fset [5];
    logic [5:0]  bad_f [6];
    logic [5:0]  bad_op [5];
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    int k;
    fset   = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    bad_f  = '{6'h00, 6'h21, 6'h23, 6'h26, 6'h28, 6'h2B};
    bad_op = '{6'h01, 6'h03, 6'h05, 6'h0F, 6'h3F};
    rs  = 5'($urandom_range(0, 7));
    rt  = 5'($urandom_range(0, 7));
    rd  = 5'($urandom_range(0, 7));
    imm = 16'($urandom);
    k   = $urandom_range(0, 11);
    case (k)
      0, 1, 2, 3, 4: return {6'h00, rs, rt, rd, 5'd0, fset[$urandom_range(0, 4)]};
      5:  return {6'h08, rs, rt, imm};
      6:  return {6'h23, rs, rt, imm};
      7:  return {6'h2B, rs, rt, imm};
      8: begin
        if ($urandom_range(0, 1) == 1) rt = rs;
        return {6'h04, rs, rt, 16'($signed($urandom_range(0, 15)) - 8)};
      end
      9:  return {6'h02, 26'($urandom)};
      10: return {6'h00, rs, rt, rd, 5'd0, bad_f[$urandom_range(0, 5)]};
      default: return {bad_op[$urandom_range(0, 4)], rs, rt, imm};
    endcase
  endfunction

  initial begin
    vec_t vecs [13];
    logic [31:0] any_reg;
    logic [31:0] ins;

    vecs = '{
      '{32'h0000_0028, 32'h0000_0000},  // unsupported funct 101000
      '{32'h2001_0005, 32'h0000_0005},  // addi $1,$0,5
      '{32'h2001_FFFD, 32'hFFFF_FFFD},  // addi $1,$0,-3
      '{32'h2002_0005, 32'h0000_0005},  // addi $2,$0,5
      '{32'h0022_1820, 32'h0000_0002},  // add $3,$1,$2
      '{32'h0041_1822, 32'h0000_0008},  // sub $3,$2,$1
      '{32'h0022_182A, 32'h0000_0001},  // slt $3,$1,$2
      '{32'h0022_1824, 32'h0000_0005},  // and $3,$1,$2
      '{32'hAC02_0008, 32'h0000_0008},  // sw $2,8($0)
      '{32'h8C04_0008, 32'h0000_0008},  // lw $4,8($0)
      '{32'h0080_2820, 32'h0000_0005},  // add $5,$4,$0
      '{32'h2000_0009, 32'h0000_0009},  // addi $0,$0,9
      '{32'h0000_1820, 32'h0000_0000}   // add $3,$0,$0
    };

    rst  = 1'b1;
    addr = 32'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset out", out, 32'd0);
    check("reset pc", dut.pc_q, 32'd0);
    rst = 1'b0;

    // Directed table; PC advances by 4 per instruction from 0
    for (int i = 0; i < 13; i++) begin
      addr = vecs[i].instr;
      @(negedge clk);
      check($sformatf("vec%0d out", i), out, vecs[i].exp_out);
      model_commit(vecs[i].instr);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d pc", i), dut.pc_q, 32'(4 * (i + 1)));
      if (i == 0) begin
        any_reg = 32'd0;
        for (int r = 0; r < 32; r++) any_reg |= dut.u_rf.regs_q[r];
        check("unsupported no reg write", any_reg, 32'd0);
      end
      if (i == 1) check("addi writes $1", dut.u_rf.regs_q[1], 32'd5);
    end
    check("$0 stays zero", dut.u_rf.regs_q[0], 32'd0);
    check("$4 loaded", dut.u_rf.regs_q[4], 32'd5);

    // Mid-cycle reset discards the pending write and clears state at once
    addr = 32'h2001_0007;  // addi $1,$0,7
    @(posedge clk);
    #1;
    check("$1 = 7", dut.u_rf.regs_q[1], 32'd7);
    addr = 32'h2001_0009;  // pending addi $1,$0,9
    #2 rst = 1'b1;
    #1;
    check("async rst pc", dut.pc_q, 32'd0);
    check("async rst $1", dut.u_rf.regs_q[1], 32'd0);
    @(posedge clk);  // edges are ignored while rst is high
    #1;
    check("rst held pc", dut.pc_q, 32'd0);
    check("rst held $1", dut.u_rf.regs_q[1], 32'd0);
    rst = 1'b0;
    model_reset();
    addr = 32'h0020_1820;  // add $3,$1,$0
    @(negedge clk);
    check("post-rst add out", out, 32'd0);
    model_commit(addr);
    @(posedge clk);
    #1;
    check("post-rst pc", dut.pc_q, 32'd4);

    // Branch/jump corners: taken beq backwards, not-taken beq, jump
    run_instr(32'h2001_0003, "setup $1", 1'b1);
    run_instr(32'h1000_FFFF, "beq taken self", 1'b1);
    check("beq self target", dut.pc_q, 32'd8);
    run_instr(32'h1020_0004, "beq not taken", 1'b1);
    check("beq fallthrough", dut.pc_q, 32'd12);
    run_instr(32'h0800_0040, "j", 1'b0);
    check("j target", dut.pc_q, 32'h0000_0100);

    // Random programs against the model
    for (int n = 0; n < 400; n++) begin
      ins = rand_instr();
      run_instr(ins, $sformatf("rand%0d %h", n, ins), ins[31:26] != 6'h02);
    end
    for (int r = 1; r < 8; r++)
      check($sformatf("final $%0d", r), dut.u_rf.regs_q[r], m_regs[r]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
